spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Register-bank controller placed behind the SPI register slave. It owns the 2**ADDR_W x REG_W configuration registers and shares them between two masters: SPI host write strobes and an on-chip core read/write port that uses a req/gnt handshake. It decodes SPI fast commands (clear, lock, unlock, error clear) and builds the 8-bit status byte that the SPI slave returns at the start of every frame.

Parameters:
ADDR_W, 3, register address width; the bank holds NUM_REGS = 2**ADDR_W registers
REG_W, 8, register width in bits (multiple of 8)
RO_MASK, 0, NUM_REGS-bit mask; bit i set makes register i read-only from SPI

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
spi_addr  in  ADDR_W  SPI register address (slave reg_addr)
spi_rdata  out  REG_W  combinational read data for spi_addr (to slave reg_data_i)
spi_wdata  in  REG_W  SPI write data (slave reg_data_o)
spi_wvld  in  1  one-cycle SPI write strobe
fastcmd  in  6  fast command code
fastcmd_vld  in  1  one-cycle fast command strobe
status  out  8  status byte to SPI slave
core_req  in  1  core access request, held until granted
core_we  in  1  1 = write, 0 = read; stable while core_req is high
core_addr  in  ADDR_W  core address; stable while core_req is high
core_wdata  in  REG_W  core write data
core_gnt  out  1  one-cycle grant pulse
core_rdata  out  REG_W  registered read data
core_rvld  out  1  pulses one cycle after a granted read
regs_flat  out  NUM_REGS*REG_W  all registers, register i at bits [i*REG_W +: REG_W]

Behaviour:
- Reset: all registers 0, FSM IDLE, lock=0, err=0, drop=0, wcnt=0, core_gnt=0, core_rvld=0, core_rdata=0.
- FSM states: IDLE and CLEAR.
- IDLE, fastcmd_vld with code 6'h01: enter CLEAR and set clr_ptr=0.
- CLEAR: zero register clr_ptr each cycle and increment clr_ptr. After writing NUM_REGS-1, return to IDLE, so CLEAR lasts exactly NUM_REGS cycles.
- Other fast commands, accepted in IDLE only: 6'h02 sets lock; 6'h03 clears lock; 6'h3F clears err and drop. Any other code sets err. Any fastcmd_vld while in CLEAR is ignored and sets err.
- SPI write, IDLE: on spi_wvld, write register spi_addr on the next clk edge unless RO_MASK[spi_addr]=1. Writes to read-only registers are silently ignored and set no flag.
- SPI write, CLEAR: spi_wvld is dropped and sets drop.
- Core arbitration: core_gnt=1 for one cycle when core_req=1, FSM is IDLE, no SPI write is applied that cycle, core_gnt was 0 in the previous cycle, and the access is not a write while lock=1.
- While lock=1, core writes stay pending (no grant). Core reads are still granted.
- Granted write: register updates on the grant edge and wcnt increments (4-bit, wraps 15 to 0).
- Granted read: core_rdata is captured on the grant edge, and core_rvld pulses the following cycle.
- SPI/core conflict: SPI wins; the core is retried on the next eligible cycle.
- Same-cycle core write and SPI read of the same address: spi_rdata shows the old value until the edge.
- status = {busy(FSM==CLEAR), lock, err, drop, wcnt[3:0]}, all registered except busy, which decodes the state register.
- Asynchronous reset during CLEAR: everything returns to reset values immediately.

Optional Feature:
SPI_REG_CTRL_FAIRNESS_EN
- Defined: a 2-bit starvation counter counts consecutive cycles in which an eligible core request lost to spi_wvld. At 3, the next conflict grants the core. The SPI write is then parked in a one-entry hold buffer and applied the following cycle with priority over everything, so it is never lost. The buffer cannot overflow because SPI strobes are at least 16 clk apart. The counter clears on any grant.
- Not defined: SPI always wins and no hold buffer exists.

Test Plan:
- Reset, then read all registers via spi_addr -> spi_rdata=0, status=8'h00, core_gnt=0.
- SPI write 8'hA5 to addr 3, then core read of addr 3 -> core_gnt pulse, core_rvld next cycle with core_rdata=8'hA5.
- fastcmd 6'h02, then core write to addr 1 with 8'h5A -> no grant while locked, status[6]=1. fastcmd 6'h03 -> grant, reg1=8'h5A, status[3:0]=1.
- Fill regs with 8'hFF, then fastcmd 6'h01 -> status[7]=1 for exactly 8 cycles and regs_flat=0 after. An spi_wvld during that window sets status[4]; a fastcmd 6'h02 during it sets status[5] and leaves lock=0.
- RO_MASK=8'h01 with SPI write of 8'h33 to addr 0 -> reg0 unchanged, status=8'h00. fastcmd 6'h15 -> status[5]=1. fastcmd 6'h3F -> status[5:4]=0.
- spi_wvld and core write in the same cycle -> SPI data lands and the core is granted the next cycle. With FAIRNESS_EN and a forced 4th consecutive conflict -> core granted and the SPI write applied one cycle later.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI/core shared register bank with fast commands and status byte
// Optional core starvation guard: define SPI_REG_CTRL_FAIRNESS_EN.
module spi_reg_ctrl #(
    parameter int ADDR_W = 3,
    parameter int REG_W = 8,
    parameter logic [(1<<ADDR_W)-1:0] RO_MASK = '0
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic [ADDR_W-1:0]               spi_addr,
    output logic [REG_W-1:0]                spi_rdata,
    input  logic [REG_W-1:0]                spi_wdata,
    input  logic                            spi_wvld,
    input  logic [5:0]                      fastcmd,
    input  logic                            fastcmd_vld,
    output logic [7:0]                      status,
    input  logic                            core_req,
    input  logic                            core_we,
    input  logic [ADDR_W-1:0]               core_addr,
    input  logic [REG_W-1:0]                core_wdata,
    output logic                            core_gnt,
    output logic [REG_W-1:0]                core_rdata,
    output logic                            core_rvld,
    output logic [(1<<ADDR_W)*REG_W-1:0]    regs_flat
);
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic [0:0] {ST_IDLE, ST_CLEAR} state_t;

    state_t             state, state_nxt;
    logic [REG_W-1:0]   regs [NUM_REGS];
    logic [ADDR_W-1:0]  clr_ptr;
    logic               lock, err, drop;
    logic [3:0]         wcnt;
    logic               gnt_q;
    logic               spi_hit, spi_apply, core_elig, core_win;
    logic               clr_cmd;

    assign spi_hit   = spi_wvld && (state == ST_IDLE);
    // Back-to-back grants are suppressed so the core sees a clean one-cycle pulse.
    assign core_elig = core_req && (state == ST_IDLE) && !gnt_q && !(core_we && lock);
    assign clr_cmd   = fastcmd_vld && (fastcmd == 6'h01) && (state == ST_IDLE);

`ifdef SPI_REG_CTRL_FAIRNESS_EN
    logic [1:0]         starv;
    logic               hold_vld;
    logic [ADDR_W-1:0]  hold_addr;
    logic [REG_W-1:0]   hold_data;

    assign core_win  = core_elig && spi_hit && (starv == 2'd3);
    assign spi_apply = spi_hit && !core_win;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starv     <= '0;
            hold_vld  <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            if (core_gnt)
                starv <= '0;
            else if (core_elig && spi_hit)
                starv <= starv + 2'd1;
            hold_vld <= core_win;
            if (core_win) begin
                hold_addr <= spi_addr;
                hold_data <= spi_wdata;
            end
        end
    end
`else
    assign core_win  = 1'b0;
    assign spi_apply = spi_hit;
`endif

    assign core_gnt  = core_elig && (!spi_hit || core_win);
    assign spi_rdata = regs[spi_addr];
    assign status    = {state == ST_CLEAR, lock, err, drop, wcnt};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_cmd) state_nxt = ST_CLEAR;
            ST_CLEAR: if (&clr_ptr) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            if (state == ST_CLEAR)
                regs[clr_ptr] <= '0;
            if (spi_apply && !RO_MASK[spi_addr])
                regs[spi_addr] <= spi_wdata;
            if (core_gnt && core_we)
                regs[core_addr] <= core_wdata;
`ifdef SPI_REG_CTRL_FAIRNESS_EN
            // Parked SPI write lands last so it overrides anything else this cycle.
            if (hold_vld && !RO_MASK[hold_addr])
                regs[hold_addr] <= hold_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            clr_ptr    <= '0;
            lock       <= 1'b0;
            err        <= 1'b0;
            drop       <= 1'b0;
            wcnt       <= '0;
            gnt_q      <= 1'b0;
            core_rvld  <= 1'b0;
            core_rdata <= '0;
        end else begin
            if (clr_cmd)
                clr_ptr <= '0;
            else if (state == ST_CLEAR)
                clr_ptr <= clr_ptr + 1'b1;

            if (fastcmd_vld) begin
                if (state == ST_CLEAR) begin
                    err <= 1'b1;
                end else begin
                    case (fastcmd)
                        6'h01: ;
                        6'h02: lock <= 1'b1;
                        6'h03: lock <= 1'b0;
                        6'h3F: begin
                            err  <= 1'b0;
                            drop <= 1'b0;
                        end
                        default: err <= 1'b1;
                    endcase
                end
            end
            if (spi_wvld && (state == ST_CLEAR))
                drop <= 1'b1;

            gnt_q     <= core_gnt;
            core_rvld <= core_gnt && !core_we;
            if (core_gnt && !core_we)
                core_rdata <= regs[core_addr];
            if (core_gnt && core_we)
                wcnt <= wcnt + 4'd1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*REG_W +: REG_W] = regs[g];
    end
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - directed self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;
    logic        clk = 1'b0;
    logic        nrst;
    logic [2:0]  spi_addr;
    logic [7:0]  spi_rdata;
    logic [7:0]  spi_wdata;
    logic        spi_wvld;
    logic [5:0]  fastcmd;
    logic        fastcmd_vld;
    logic [7:0]  status;
    logic        core_req;
    logic        core_we;
    logic [2:0]  core_addr;
    logic [7:0]  core_wdata;
    logic        core_gnt;
    logic [7:0]  core_rdata;
    logic        core_rvld;
    logic [63:0] regs_flat;

    int checks = 0;
    int failures = 0;

    spi_reg_ctrl #(.ADDR_W(3), .REG_W(8), .RO_MASK(8'h01)) dut (
        .clk(clk), .nrst(nrst),
        .spi_addr(spi_addr), .spi_rdata(spi_rdata), .spi_wdata(spi_wdata), .spi_wvld(spi_wvld),
        .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld), .status(status),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvld(core_rvld),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [2:0] a, input logic [7:0] d);
        bit done = 0;
        int n = 0;
        core_req = 1'b1; core_we = 1'b1; core_addr = a; core_wdata = d;
        #1;
        while (!done && n < 20) begin
            if (core_gnt) done = 1;
            step;
            n++;
        end
        check_eq("core_write_granted", 64'(done), 64'd1);
        core_req = 1'b0; core_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0;
        spi_addr = '0; spi_wdata = '0; spi_wvld = 1'b0;
        fastcmd = '0; fastcmd_vld = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        #1;
        check_eq("rst_status", 64'(status), 64'h00);
        check_eq("rst_gnt", 64'(core_gnt), 64'd0);
        check_eq("rst_rvld", 64'(core_rvld), 64'd0);
        check_eq("rst_rdata", 64'(core_rdata), 64'h00);
        check_eq("rst_flat", regs_flat, 64'h0);
        for (int i = 0; i < 8; i++) begin
            spi_addr = 3'(i);
            #1 check_eq("rst_spi_rdata", 64'(spi_rdata), 64'h00);
        end

        // SPI write then core read of addr 3
        step;
        spi_addr = 3'd3; spi_wdata = 8'hA5; spi_wvld = 1'b1;
        step;
        spi_wvld = 1'b0;
        #1 check_eq("spi_rd3", 64'(spi_rdata), 64'hA5);
        core_req = 1'b1; core_we = 1'b0; core_addr = 3'd3;
        #1 check_eq("rd_gnt", 64'(core_gnt), 64'd1);
        step;
        core_req = 1'b0;
        #1;
        check_eq("rd_gnt_pulse", 64'(core_gnt), 64'd0);
        check_eq("rd_rvld", 64'(core_rvld), 64'd1);
        check_eq("rd_rdata", 64'(core_rdata), 64'hA5);
        step;
        check_eq("rd_rvld_pulse", 64'(core_rvld), 64'd0);

        // lock blocks core writes
        fastcmd = 6'h02; fastcmd_vld = 1'b1;
        step;
        fastcmd_vld = 1'b0;
        check_eq("lock_status", 64'(status), 64'h40);
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd1; core_wdata = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            #1 check_eq("locked_no_gnt", 64'(core_gnt), 64'd0);
            step;
        end
        fastcmd = 6'h03; fastcmd_vld = 1'b1;
        #1 check_eq("unlock_cycle_no_gnt", 64'(core_gnt), 64'd0);
        step;
        fastcmd_vld = 1'b0;
        #1 check_eq("unlocked_gnt", 64'(core_gnt), 64'd1);
        step;
        core_req = 1'b0; core_we = 1'b0;
        #1;
        check_eq("reg1", 64'(regs_flat[15:8]), 64'h5A);
        check_eq("wcnt1_status", 64'(status), 64'h01);

        // fill, then clear with drop/err provoked mid-clear
        for (int i = 0; i < 8; i++) core_write(3'(i), 8'hFF);
        check_eq("filled", regs_flat, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("fill_status", 64'(status), 64'h09);
        fastcmd = 6'h01; fastcmd_vld = 1'b1;
        step;
        fastcmd_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("clear_busy", 64'(status[7]), 64'd1);
            if (k == 2) begin
                spi_addr = 3'd5; spi_wdata = 8'h11; spi_wvld = 1'b1;
            end
            if (k == 4) begin
                fastcmd = 6'h02; fastcmd_vld = 1'b1;
            end
            step;
            spi_wvld = 1'b0; fastcmd_vld = 1'b0;
        end
        check_eq("clear_done", 64'(status[7]), 64'd0);
        check_eq("cleared", regs_flat, 64'h0);
        check_eq("clear_status", 64'(status), 64'h39);

        // read-only reg 0, bad command, error clear
        fastcmd = 6'h3F; fastcmd_vld = 1'b1;
        step;
        fastcmd_vld = 1'b0;
        check_eq("errclr_status", 64'(status), 64'h09);
        spi_addr = 3'd0; spi_wdata = 8'h33; spi_wvld = 1'b1;
        step;
        spi_wvld = 1'b0;
        check_eq("ro_reg0", 64'(regs_flat[7:0]), 64'h00);
        check_eq("ro_status", 64'(status), 64'h09);
        fastcmd = 6'h15; fastcmd_vld = 1'b1;
        step;
        fastcmd_vld = 1'b0;
        check_eq("badcmd_status", 64'(status), 64'h29);
        fastcmd = 6'h3F; fastcmd_vld = 1'b1;
        step;
        fastcmd_vld = 1'b0;
        check_eq("errclr2_status", 64'(status), 64'h09);

        // SPI/core same-cycle conflict
        spi_addr = 3'd2; spi_wdata = 8'h77; spi_wvld = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd4; core_wdata = 8'h44;
        #1 check_eq("conflict_no_gnt", 64'(core_gnt), 64'd0);
        step;
        spi_wvld = 1'b0;
        #1;
        check_eq("conflict_spi_reg2", 64'(regs_flat[23:16]), 64'h77);
        check_eq("conflict_retry_gnt", 64'(core_gnt), 64'd1);
        step;
        core_req = 1'b0;
        check_eq("conflict_reg4", 64'(regs_flat[39:32]), 64'h44);
        check_eq("conflict_status", 64'(status), 64'h0A);
        step;

        // four consecutive conflicts
        spi_addr = 3'd6;
        core_req = 1'b1; core_we = 1'b1; core_addr = 3'd5; core_wdata = 8'h55;
        for (int k = 0; k < 4; k++) begin
            spi_wdata = 8'h60 + 8'(k); spi_wvld = 1'b1;
            #1;
`ifdef SPI_REG_CTRL_FAIRNESS_EN
            check_eq("fair_gnt", 64'(core_gnt), (k == 3) ? 64'd1 : 64'd0);
`else
            check_eq("spi_wins_gnt", 64'(core_gnt), 64'd0);
`endif
            step;
        end
        spi_wvld = 1'b0;
`ifdef SPI_REG_CTRL_FAIRNESS_EN
        core_req = 1'b0;
        #1;
        check_eq("fair_reg5", 64'(regs_flat[47:40]), 64'h55);
        check_eq("fair_reg6_before", 64'(regs_flat[55:48]), 64'h62);
        step;
        check_eq("fair_reg6_held", 64'(regs_flat[55:48]), 64'h63);
`else
        #1;
        check_eq("late_gnt", 64'(core_gnt), 64'd1);
        check_eq("spi_reg6", 64'(regs_flat[55:48]), 64'h63);
        step;
        core_req = 1'b0;
        check_eq("late_reg5", 64'(regs_flat[47:40]), 64'h55);
`endif
        check_eq("final_status", 64'(status), 64'h0B);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
